// File: rtl/instr_encoder_if.sv
// Request and instruction-memory bus for the instruction encoder/loader.
// master = request producer and memory side, slave = the encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  // Request channel
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;

  // Instruction-memory write channel
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // Loader status
  logic              full;
  logic              err;
  logic [ADDR_W:0]   instr_count;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, full, err, instr_count
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, full, err, instr_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level MIPS instruction requests into 32-bit words, buffers them
// in a 2-entry FIFO and writes them to instruction memory at consecutive word
// addresses starting at BASE_ADDR.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  instr_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_LW  = 3'd1;
  localparam logic [2:0] KIND_SW  = 3'd2;
  localparam logic [2:0] KIND_BEQ = 3'd3;
  localparam logic [2:0] KIND_J   = 3'd4;

  // FIFO occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q;
  logic [31:0]       head_q, tail_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              full_q, err_q;

  logic [31:0] word_d;
  logic        legal_d;
  logic        accept, push, pop;

  // Encode the request fields into a MIPS word according to the kind
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    word_d  = '0;
    legal_d = 1'b1;
    case (bus.in_kind)
      KIND_R:   word_d = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      KIND_LW:  word_d = {6'd35, bus.in_rs, bus.in_rt, bus.in_imm};
      KIND_SW:  word_d = {6'd43, bus.in_rs, bus.in_rt, bus.in_imm};
      KIND_BEQ: word_d = {6'd4, bus.in_rs, bus.in_rt, bus.in_imm};
      KIND_J:   word_d = {6'd2, bus.in_target};
      default:  legal_d = 1'b0;
    endcase
  end

  // Handshake and drain control; reset/clear suppress both sides in the same cycle
  always_comb begin
    bus.mem_we   = !reset && !clear && (state_q != ST_EMPTY) && !full_q;
    pop          = bus.mem_we && bus.mem_ready;
    bus.in_ready = !reset && !clear && !full_q && ((state_q != ST_TWO) || pop);
    accept       = bus.in_valid && bus.in_ready;
    push         = accept && legal_d;
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = head_q;
  assign bus.full        = full_q;
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;

  // Two-entry FIFO: head_q is the word being offered to memory
  always_ff @(posedge clk) begin
    // NOTE: the FIFO storage is reset too, because mem_wdata must read 0 after reset.
    if (reset || clear) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so head/tail shift reads the old tail value.
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_q  <= word_d;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_q <= word_d;
          end else if (push) begin
            tail_q  <= word_d;
            state_q <= ST_TWO;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (push && pop) begin
            head_q <= tail_q;
            tail_q <= word_d;
          end else if (pop) begin
            head_q  <= tail_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Write pointer, word count and sticky status flags
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      addr_q  <= BASE_PTR;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept && !legal_d) err_q <= 1'b1;
      if (pop) begin
        count_q <= count_q + 1'b1;
        // The last location saturates the pointer instead of wrapping
        if (addr_q == LAST_PTR) full_q <= 1'b1;
        else                    addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares on every memory write.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear0, clear1;

  instr_encoder_if #(.ADDR_W(8)) if0 ();
  instr_encoder_if #(.ADDR_W(2)) if1 ();

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear0), .bus(if0.slave)
  );
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .clear(clear1), .bus(if1.slave)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   exp_addr0 = 0;
  int   exp_addr1 = 0;
  int   n_checks  = 0;
  int   n_err     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int sel);
    if (sel == 0) if0.in_valid = 1'b0;
    else          if1.in_valid = 1'b0;
  endtask

  task automatic drive(input int sel, input logic [2:0] kind,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt);
    if (sel == 0) begin
      if0.in_valid = 1'b1; if0.in_kind = kind; if0.in_rs = rs; if0.in_rt = rt;
      if0.in_rd = rd; if0.in_shamt = sh; if0.in_funct = fn; if0.in_imm = imm;
      if0.in_target = tgt;
    end else begin
      if1.in_valid = 1'b1; if1.in_kind = kind; if1.in_rs = rs; if1.in_rt = rt;
      if1.in_rd = rd; if1.in_shamt = sh; if1.in_funct = fn; if1.in_imm = imm;
      if1.in_target = tgt;
    end
  endtask

  // Wait (bounded) for the handshake; record the expected write on acceptance
  task automatic wait_accept(input int sel, input bit legal, input logic [31:0] word);
    bit   done = 1'b0;
    exp_t e;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (((sel == 0) ? if0.in_ready : if1.in_ready) === 1'b1) begin
        @(posedge clk);
        if (legal) begin
          if (sel == 0) begin
            e.addr = 8'(exp_addr0); e.data = word; q0.push_back(e); exp_addr0++;
          end else begin
            e.addr = 8'(exp_addr1); e.data = word; q1.push_back(e); exp_addr1++;
          end
        end
        done = 1'b1;
      end
    end
    #1;
    idle(sel);
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: in_ready never seen, expected handshake", sel);
    end
  endtask

  task automatic send(input int sel, input logic [2:0] kind,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] word);
    drive(sel, kind, rs, rt, rd, sh, fn, imm, tgt);
    wait_accept(sel, kind <= 3'd4, word);
  endtask

  task automatic pulse_clear0();
    clear0 = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 32'(if0.in_ready), 32'd0);
    check("clear_mem_we",   32'(if0.mem_we),   32'd0);
    @(posedge clk);
    #1;
    clear0 = 1'b0;
    idle(0);
    q0.delete();
    exp_addr0 = 0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (if0.mem_we === 1'b1 && if0.mem_ready === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut0_unexpected_write: addr=0x%0h data=0x%08h, expected no write",
                 if0.mem_addr, if0.mem_wdata);
      end else begin
        e = q0.pop_front();
        check("dut0_addr", 32'(if0.mem_addr), 32'(e.addr));
        check("dut0_data", if0.mem_wdata, e.data);
      end
    end
    if (if1.mem_we === 1'b1 && if1.mem_ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut1_unexpected_write: addr=0x%0h data=0x%08h, expected no write",
                 if1.mem_addr, if1.mem_wdata);
      end else begin
        e = q1.pop_front();
        check("dut1_addr", 32'(if1.mem_addr), 32'(e.addr));
        check("dut1_data", if1.mem_wdata, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; clear0 = 1'b0; clear1 = 1'b0;
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    drive(1, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    idle(0); idle(1);
    if0.mem_ready = 1'b1;
    if1.mem_ready = 1'b1;
    step(2);

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 32'(if0.in_ready),    32'd0);
    check("rst_mem_we",   32'(if0.mem_we),      32'd0);
    check("rst_mem_addr", 32'(if0.mem_addr),    32'd0);
    check("rst_wdata",    if0.mem_wdata,        32'd0);
    check("rst_full",     32'(if0.full),        32'd0);
    check("rst_err",      32'(if0.err),         32'd0);
    check("rst_count",    32'(if0.instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;

    // Each instruction kind, mem_ready=1; beq carries junk rd/funct to be ignored
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'd0, 32'h00221820);
    @(negedge clk);
    check("latency_mem_we",   32'(if0.mem_we),   32'd1);
    check("latency_mem_addr", 32'(if0.mem_addr), 32'd0);
    @(posedge clk); #1;
    send(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0, 32'h8C220004);
    send(0, 3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0, 32'hAC220004);
    send(0, 3'd3, 5'd1, 5'd2, 5'd7, 5'd9, 6'h3F, 16'hFFFF, 26'd0, 32'h1022FFFF);
    send(0, 3'd4, 5'd1, 5'd2, 5'd3, 5'd4, 6'h3F, 16'h1234, 26'h100, 32'h08000100);
    step(3);
    @(negedge clk);
    check("kinds_count",   32'(if0.instr_count), 32'd5);
    check("kinds_drained", 32'(q0.size()),       32'd0);
    @(posedge clk); #1;

    // Backpressure: two accepted, third stalls until memory accepts
    pulse_clear0();
    if0.mem_ready = 1'b0;
    send(0, 3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'd0, 26'd0, 32'h00853080);
    send(0, 3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0010, 26'd0, 32'h8FA80010);
    drive(0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h3FFFFFF);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(if0.in_ready), 32'd0);
      check("bp_mem_we",   32'(if0.mem_we),   32'd1);
      check("bp_addr",     32'(if0.mem_addr), 32'd0);
      check("bp_wdata",    if0.mem_wdata,     32'h00853080);
    end
    @(posedge clk); #1;
    if0.mem_ready = 1'b1;
    wait_accept(0, 1'b1, 32'h0BFFFFFF);
    step(4);
    @(negedge clk);
    check("bp_count",   32'(if0.instr_count), 32'd3);
    check("bp_drained", 32'(q0.size()),       32'd0);
    @(posedge clk); #1;

    // Illegal kind between two legal requests
    pulse_clear0();
    send(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0, 32'h8C220004);
    @(negedge clk);
    check("err_before", 32'(if0.err), 32'd0);
    @(posedge clk); #1;
    send(0, 3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0004, 26'd0, 32'h0);
    @(negedge clk);
    check("err_after", 32'(if0.err), 32'd1);
    @(posedge clk); #1;
    send(0, 3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0, 32'hAC220004);
    step(3);
    @(negedge clk);
    check("illegal_count",   32'(if0.instr_count), 32'd2);
    check("illegal_err",     32'(if0.err),         32'd1);
    check("illegal_drained", 32'(q0.size()),       32'd0);
    @(posedge clk); #1;

    // clear with two words buffered and memory stalled, plus a competing request
    if0.mem_ready = 1'b0;
    send(0, 3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h0008, 26'd0, 32'h8C640008);
    send(0, 3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h0008, 26'd0, 32'hAC640008);
    drive(0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000042);
    pulse_clear0();
    @(negedge clk);
    check("clr_mem_we", 32'(if0.mem_we),      32'd0);
    check("clr_count",  32'(if0.instr_count), 32'd0);
    check("clr_err",    32'(if0.err),         32'd0);
    check("clr_full",   32'(if0.full),        32'd0);
    check("clr_addr",   32'(if0.mem_addr),    32'd0);
    @(posedge clk); #1;
    if0.mem_ready = 1'b1;
    send(0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000042, 32'h08000042);
    step(3);

    // reset mid-stream with a simultaneous request
    if0.mem_ready = 1'b0;
    send(0, 3'd3, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h0002, 26'd0, 32'h10A60002);
    send(0, 3'd3, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h0003, 26'd0, 32'h10A60003);
    reset = 1'b1;
    drive(0, 3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0001, 26'd0);
    @(posedge clk); #1;
    q0.delete(); exp_addr0 = 0;
    q1.delete(); exp_addr1 = 0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(if0.in_ready),    32'd0);
    check("mid_rst_mem_we",   32'(if0.mem_we),      32'd0);
    check("mid_rst_addr",     32'(if0.mem_addr),    32'd0);
    check("mid_rst_wdata",    if0.mem_wdata,        32'd0);
    check("mid_rst_full",     32'(if0.full),        32'd0);
    check("mid_rst_err",      32'(if0.err),         32'd0);
    check("mid_rst_count",    32'(if0.instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(0);
    if0.mem_ready = 1'b1;
    @(negedge clk);
    check("post_mid_rst_mem_we", 32'(if0.mem_we), 32'd0);
    @(posedge clk); #1;
    send(0, 3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h0020, 26'd0, 32'h8C430020);
    step(3);

    // Full on a 4-word memory
    send(1, 3'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00000820);
    send(1, 3'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00001020);
    send(1, 3'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00001820);
    send(1, 3'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00002020);
    @(negedge clk);
    check("last_write_we",   32'(if1.mem_we),   32'd1);
    check("last_write_addr", 32'(if1.mem_addr), 32'd3);
    check("last_write_full", 32'(if1.full),     32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_set",    32'(if1.full),        32'd1);
    check("full_mem_we", 32'(if1.mem_we),      32'd0);
    check("full_count",  32'(if1.instr_count), 32'd4);
    @(posedge clk); #1;
    drive(1, 3'd0, 5'd0, 5'd0, 5'd5, 5'd0, 6'h20, 16'd0, 26'd0);
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", 32'(if1.in_ready), 32'd0);
      check("full_we_held",  32'(if1.mem_we),   32'd0);
    end
    @(posedge clk); #1;
    idle(1);
    @(negedge clk);
    check("full_count_held", 32'(if1.instr_count), 32'd4);

    // Every expected write must have been observed
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
